// File: rtl/fft_pkg.sv
// Shared definitions for the FFT controller slice.
//   state_t      : controller FSM states
//   DEF_N/LOG2N  : default transform size
//   BANK_A/B     : ping-pong bank encoding (0 = AMEM, 1 = BMEM)
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_N     = 1024;
    localparam int DEF_LOG2N = 10;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

endpackage

// File: rtl/fft_agu.sv
// Radix-2 DIT address generator (purely combinational).
//   s     : stage index, 0..LOG2N-1
//   k     : butterfly index within the stage, 0..N/2-1
//   addr0 : upper butterfly leg address
//   addr1 : lower leg address (addr0 + 2^s)
//   tw    : twiddle ROM address
module fft_agu
    import fft_pkg::*;
#(
    parameter int LOG2N = DEF_LOG2N,
    parameter int S_W   = $clog2(LOG2N)
) (
    input  logic [S_W-1:0]   s,
    input  logic [LOG2N-2:0] k,
    output logic [LOG2N-1:0] addr0,
    output logic [LOG2N-1:0] addr1,
    output logic [LOG2N-2:0] tw
);

    logic [LOG2N-1:0] k_ext;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;

    always_comb begin
        k_ext = {1'b0, k};
        span  = LOG2N'(1) << s;
        pos   = k_ext & (span - LOG2N'(1));
        grp   = k_ext >> s;
        // Group base spaces groups 2*span apart; pos is the offset inside it.
        addr0 = (grp << (s + 1)) | pos;
        // Bit s of addr0 is always clear, so OR equals the addition.
        addr1 = addr0 | span;
        // pos < 2^s, so the shifted value always fits in LOG2N-1 bits.
        tw    = pos[LOG2N-2:0] << (LOG2N - 1 - int'(s));
    end

endmodule

// File: rtl/fft_ctrl.sv
// FFT stage sequencer: runs all LOG2N radix-2 stages over the AMEM/BMEM
// ping-pong banks, one butterfly per cycle.
//   clk, rst          : clock, synchronous active-high reset
//   start             : run request, ignored while busy
//   addr0/1_rd_MEM    : read addresses shared by both banks
//   addr_CROM         : twiddle ROM address
//   sel_mux           : bank the datapath takes read data from (1 cycle late)
//   en_REG            : 0 = datapath registers load, 1 = hold
//   addr0/1_wr_MEM    : write-back addresses (issue + 2 cycles)
//   we_AMEM, we_BMEM  : bank write enables
//   busy, done        : run in progress / one-cycle completion pulse
//   result_bank       : bank holding the final result
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int LOG2N = DEF_LOG2N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [LOG2N-1:0] addr0_rd_MEM,
    output logic [LOG2N-1:0] addr1_rd_MEM,
    output logic [LOG2N-2:0] addr_CROM,
    output logic             sel_mux,
    output logic             en_REG,
    output logic [LOG2N-1:0] addr0_wr_MEM,
    output logic [LOG2N-1:0] addr1_wr_MEM,
    output logic             we_AMEM,
    output logic             we_BMEM,
    output logic             busy,
    output logic             done,
    output logic             result_bank
);

    localparam int               S_W    = $clog2(LOG2N);
    localparam logic [S_W-1:0]   S_LAST = S_W'(LOG2N - 1);
    localparam logic [LOG2N-2:0] K_LAST = (LOG2N - 1)'(N / 2 - 1);

    state_t           state_reg, state_next;
    logic [S_W-1:0]   s_reg, s_next;
    logic [LOG2N-2:0] k_reg, k_next;
    logic             drain_reg, drain_next;

    // Two-deep pipe: stage 1 aligns with read data, stage 2 with BF output.
    logic             v1_reg, v2_reg;
    logic             bank1_reg, bank2_reg;
    logic [LOG2N-1:0] a0_1_reg, a1_1_reg, a0_2_reg, a1_2_reg;

    logic             issue;
    logic [LOG2N-1:0] agu_a0, agu_a1;
    logic [LOG2N-2:0] agu_tw;

    fft_agu #(
        .LOG2N (LOG2N),
        .S_W   (S_W)
    ) u_agu (
        .s     (s_reg),
        .k     (k_reg),
        .addr0 (agu_a0),
        .addr1 (agu_a1),
        .tw    (agu_tw)
    );

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        k_next     = k_reg;
        drain_next = drain_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    s_next     = '0;
                    k_next     = '0;
                end
            end
            RUN: begin
                k_next = k_reg + 1'b1;
                if (k_reg == K_LAST) begin
                    state_next = DRAIN;
                    drain_next = 1'b0;
                    k_next     = '0;
                end
            end
            DRAIN: begin
                drain_next = 1'b1;
                if (drain_reg) begin
                    drain_next = 1'b0;
                    if (s_reg != S_LAST) begin
                        s_next     = s_reg + 1'b1;
                        state_next = RUN;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                s_next     = '0;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            k_reg     <= '0;
            drain_reg <= 1'b0;
            v1_reg    <= 1'b0;
            v2_reg    <= 1'b0;
            bank1_reg <= BANK_A;
            bank2_reg <= BANK_A;
            a0_1_reg  <= '0;
            a1_1_reg  <= '0;
            a0_2_reg  <= '0;
            a1_2_reg  <= '0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            k_reg     <= k_next;
            drain_reg <= drain_next;
            v1_reg    <= issue;
            v2_reg    <= v1_reg;
            // Even stages read AMEM, odd stages read BMEM.
            bank1_reg <= issue ? s_reg[0] : BANK_A;
            bank2_reg <= bank1_reg;
            a0_1_reg  <= addr0_rd_MEM;
            a1_1_reg  <= addr1_rd_MEM;
            a0_2_reg  <= a0_1_reg;
            a1_2_reg  <= a1_1_reg;
        end
    end

    assign issue        = (state_reg == RUN);
    assign addr0_rd_MEM = issue ? agu_a0 : '0;
    assign addr1_rd_MEM = issue ? agu_a1 : '0;
    assign addr_CROM    = issue ? agu_tw : '0;

    assign sel_mux      = bank1_reg;
    assign en_REG       = ~v1_reg;

    // Results go to the bank opposite to the one that was read.
    assign addr0_wr_MEM = a0_2_reg;
    assign addr1_wr_MEM = a1_2_reg;
    assign we_AMEM      = v2_reg & (bank2_reg == BANK_B);
    assign we_BMEM      = v2_reg & (bank2_reg == BANK_A);

    assign busy         = (state_reg != IDLE);
    assign done         = (state_reg == DONE);
    assign result_bank  = ((LOG2N % 2) == 1);

endmodule

// File: tb/tb_fft_ctrl.sv
module tb_fft_ctrl;

    localparam int N   = 8;
    localparam int L   = 3;
    localparam int PER = N / 2 + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [L-1:0] addr0_rd_MEM, addr1_rd_MEM, addr0_wr_MEM, addr1_wr_MEM;
    logic [L-2:0] addr_CROM;
    logic         sel_mux, en_REG, we_AMEM, we_BMEM, busy, done, result_bank;

    fft_ctrl #(.N(N), .LOG2N(L)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .addr0_rd_MEM (addr0_rd_MEM),
        .addr1_rd_MEM (addr1_rd_MEM),
        .addr_CROM    (addr_CROM),
        .sel_mux      (sel_mux),
        .en_REG       (en_REG),
        .addr0_wr_MEM (addr0_wr_MEM),
        .addr1_wr_MEM (addr1_wr_MEM),
        .we_AMEM      (we_AMEM),
        .we_BMEM      (we_BMEM),
        .busy         (busy),
        .done         (done),
        .result_bank  (result_bank)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int a0;
        int a1;
        int tw;
        int bank;
    } ev_t;

    ev_t rd_q[$];
    ev_t wr_q[$];
    int  done_q[$];

    int cyc       = 0;
    int n_chk     = 0;
    int n_pass    = 0;
    int busy_lo   = 1;
    int busy_hi   = 0;
    int idle_from = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    // Reference model: every read issue, write-back and done pulse of a run
    // started in cycle c, from the stage/butterfly arithmetic.
    task automatic push_run(input int c);
        int span, t, a0, tw;
        for (int s = 0; s < L; s++) begin
            for (int k = 0; k < N / 2; k++) begin
                span = 1 << s;
                t    = c + 1 + s * PER + k;
                a0   = (k / span) * 2 * span + (k % span);
                tw   = (k % span) * ((N / 2) / span);
                rd_q.push_back('{t, a0, a0 + span, tw, s % 2});
                wr_q.push_back('{t + 2, a0, a0 + span, 0, (s % 2 == 0) ? 1 : 0});
            end
        end
        done_q.push_back(c + L * PER + 1);
        busy_lo   = c + 1;
        busy_hi   = c + L * PER + 1;
        idle_from = busy_hi + 1;
    endtask

    // Reset sampled at the end of cycle r: anything due later never happens.
    task automatic flush(input int r);
        while (rd_q.size() > 0 && rd_q[$].t >= r) void'(rd_q.pop_back());
        while (wr_q.size() > 0 && wr_q[$].t > r) void'(wr_q.pop_back());
        while (done_q.size() > 0 && done_q[$] > r) void'(done_q.pop_back());
        if (busy_hi > r) busy_hi = r;
        idle_from = r + 1;
    endtask

    task automatic cycle(input bit st, input bit rs);
        start = st;
        rst   = rs;
        if (rs) flush(cyc);
        else if (st && cyc >= idle_from) begin
            push_run(cyc);
            $display("start accepted @cycle %0d", cyc);
        end else if (st) begin
            $display("start ignored @cycle %0d (busy)", cyc);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares DUT activity against the queued expectations.
    int  prev_a0 = 0, prev_a1 = 0, prev_tw = 0;
    ev_t e;

    always @(negedge clk) begin
        chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
        if (!en_REG) begin
            if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
            else begin
                e = rd_q.pop_front();
                chk("rd_cycle", cyc - 1, e.t);
                chk("rd_addr0", prev_a0, e.a0);
                chk("rd_addr1", prev_a1, e.a1);
                chk("rd_crom", prev_tw, e.tw);
                chk("sel_mux", sel_mux, e.bank);
                $display("read  @%0d: (%0d,%0d) tw=%0d bank=%0d", cyc - 1, prev_a0, prev_a1, prev_tw, sel_mux);
            end
        end
        prev_a0 = int'(addr0_rd_MEM);
        prev_a1 = int'(addr1_rd_MEM);
        prev_tw = int'(addr_CROM);
        if (we_AMEM || we_BMEM) begin
            chk("we_exclusive", we_AMEM && we_BMEM, 0);
            if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                e = wr_q.pop_front();
                chk("wr_cycle", cyc, e.t);
                chk("wr_bank", we_BMEM, e.bank);
                chk("wr_addr0", addr0_wr_MEM, e.a0);
                chk("wr_addr1", addr1_wr_MEM, e.a1);
                $display("write @%0d: (%0d,%0d) bank=%0d", cyc, addr0_wr_MEM, addr1_wr_MEM, we_BMEM);
            end
        end
        if (done) begin
            if (done_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                chk("done_cycle", cyc, done_q.pop_front());
                $display("done  @%0d", cyc);
            end
        end
    end

    int c, ign, rs_off;

    initial begin
        start = 1'b0;
        rst   = 1'b1;
        repeat (3) cycle(1'b0, 1'b1);
        chk("rst_addr0_rd", addr0_rd_MEM, 0);
        chk("rst_addr1_rd", addr1_rd_MEM, 0);
        chk("rst_crom", addr_CROM, 0);
        chk("rst_addr0_wr", addr0_wr_MEM, 0);
        chk("rst_addr1_wr", addr1_wr_MEM, 0);
        chk("rst_sel", sel_mux, 0);
        chk("rst_en_reg", en_REG, 1);
        chk("rst_we", {we_AMEM, we_BMEM}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("result_bank", result_bank, 1);
        cycle(1'b0, 1'b0);

        // Directed run with ignored starts, then back-to-back restart.
        c = cyc;
        cycle(1'b1, 1'b0);
        for (int off = 1; off < 20; off++) cycle(off == 5 || off == 10, 1'b0);
        cycle(1'b1, 1'b0);
        // Second run is cut by reset, then restarted cleanly.
        c = cyc - 1;
        for (int off = 1; off < 8; off++) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        for (int off = 9; off < 12; off++) cycle(1'b0, 1'b0);
        chk("idle_after_rst", busy, 0);
        cycle(1'b1, 1'b0);
        while (cyc < idle_from) cycle(1'b0, 1'b0);

        // Randomized runs with stray starts and occasional resets.
        for (int it = 0; it < 6; it++) begin
            repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0);
            ign    = int'($urandom_range(2, 18));
            rs_off = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 18)) : -1;
            cycle(1'b1, 1'b0);
            for (int off = 1; off <= 20; off++) cycle(off == ign, off == rs_off);
            while (cyc < idle_from) cycle(1'b0, 1'b0);
        end

        for (int i = 0; i < 100 && (rd_q.size() + wr_q.size() + done_q.size()) > 0; i++)
            cycle(1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0);
        chk("queues_drained", rd_q.size() + wr_q.size() + done_q.size(), 0);
        chk("final_idle", busy, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
